// File: rtl/i2c_target.sv
// I2C target (7-bit address) with byte-wide write/read handshakes to local logic.
// SCL/SDA are synchronized into the clk domain; SCL is never stretched.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_byte,
    output logic       tx_req,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ACK_ADDR  = 4'd2,
        ST_RX_BYTE   = 4'd3,
        ST_ACK_RX    = 4'd4,
        ST_TX_BYTE   = 4'd5,
        ST_ACK_TX    = 4'd6,
        ST_WAIT_STOP = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;
    logic        sda_oe_q, sda_oe_d;
    logic        rw_q, rw_d;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Open-drain: the pin is only ever pulled low or left floating.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
        end
    end

    // Bus conditions win over bit sampling; a STOP always aborts to idle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q[6:0] == ADDR) begin
                                rw_d    = sda_sync_q;
                                state_d = ST_ACK_ADDR;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // First falling edge starts the ACK, the second ends it.
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX_BYTE;
                        end else begin
                            state_d    = ST_TX_BYTE;
                            tx_req_d   = 1'b1;
                            tx_shift_d = {tx_byte[6:0], 1'b0};
                            sda_oe_d   = ~tx_byte[7];
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d  = {shift_q[6:0], sda_sync_q};
                            rx_valid_d = 1'b1;
                            state_d    = ST_ACK_RX;
                        end
                    end
                end
                ST_ACK_RX: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX_BYTE;
                        end
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        sda_oe_d   = ~tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACK_TX;
                        end
                    end
                end
                // Controller ACK loads the next byte; its first bit goes out on the next fall.
                ST_ACK_TX: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_sync_q) begin
                            state_d    = ST_TX_BYTE;
                            tx_req_d   = 1'b1;
                            tx_shift_d = tx_byte;
                            bit_cnt_d  = 3'd0;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign tx_req   = tx_req_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign state    = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level I2C controller plus a transaction
// model predicting ACK slots, read-back bytes, rx_valid data and tx_req counts.
module tb_i2c_target;

    localparam logic [6:0] TGT = 7'h42;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_drv;
    logic       sda_low;
    logic [7:0] tx_byte;
    logic       tx_req;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;
    logic [3:0] state;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(TGT)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl_drv),
        .sda      (sda_bus),
        .tx_byte  (tx_byte),
        .tx_req   (tx_req),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .busy     (busy),
        .state    (state)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         tx_seen = 0;
    int         tx_exp  = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_front;
    logic       rxv_prev = 1'b0;
    logic       sel_model;
    logic       wr_model;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: every rx_valid must carry the next byte the model expects.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                vectors++;
                if (exp_rx.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rx_valid: got rx_valid=1 rx_byte=%0h, expected rx_valid=0", rx_byte);
                end else begin
                    exp_front = exp_rx.pop_front();
                    if (rx_byte !== exp_front) begin
                        errors++;
                        $display("[TB] FAIL rx_byte: got %0h, expected %0h", rx_byte, exp_front);
                    end
                end
                vectors++;
                if (rxv_prev) begin
                    errors++;
                    $display("[TB] FAIL rx_valid_width: got 2+ cycles, expected 1");
                end
            end
            if (tx_req) tx_seen++;
        end
        rxv_prev <= rx_valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_low = !b;
        wait_clks(6);
        scl_drv = 1'b1;
        wait_clks(5);
        s = sda_bus;
        wait_clks(5);
        scl_drv = 1'b0;
        wait_clks(2);
    endtask

    task automatic xfer(input logic [8:0] out_w, output logic [8:0] in_w);
        logic s;
        for (int i = 8; i >= 0; i--) begin
            send_bit(out_w[i], s);
            in_w[i] = s;
        end
    endtask

    task automatic start_cond();
        sda_low = 1'b0;
        wait_clks(4);
        scl_drv = 1'b1;
        wait_clks(6);
        sda_low = 1'b1;
        wait_clks(8);
        scl_drv = 1'b0;
        wait_clks(2);
    endtask

    task automatic stop_cond();
        sda_low = 1'b1;
        wait_clks(4);
        scl_drv = 1'b1;
        wait_clks(6);
        sda_low = 1'b0;
        wait_clks(8);
        sel_model = 1'b0;
    endtask

    // Address byte: target ACKs only its own address; R/W=0 starts a read and a tx_req.
    task automatic addr_phase(input logic [7:0] a);
        logic [8:0] got;
        sel_model = (a[7:1] == TGT);
        wr_model  = a[0];
        if (sel_model && !wr_model) tx_exp++;
        xfer({a, 1'b1}, got);
        check_output("addr_byte", got, {a, sel_model ? 1'b0 : 1'b1});
    endtask

    task automatic write_phase(input logic [7:0] d);
        logic [8:0] got;
        logic       taken;
        taken = sel_model && wr_model;
        if (taken) exp_rx.push_back(d);
        xfer({d, 1'b1}, got);
        check_output("write_byte", got, {d, taken ? 1'b0 : 1'b1});
    endtask

    task automatic read_phase(input logic ack, input logic [7:0] tx);
        logic [8:0] got;
        if (!ack) tx_exp++;
        xfer({8'hFF, ack}, got);
        check_output("read_byte", got, {tx, ack});
    endtask

    task automatic end_checks();
        wait_clks(4);
        check_output("idle_state", state, 4'd0);
        check_output("idle_busy", busy, 1'b0);
        check_output("rx_pending", exp_rx.size(), 0);
        check_output("tx_req_count", tx_seen, tx_exp);
    endtask

    task automatic apply_stimulus();
        logic       s;
        logic [7:0] partial;

        // Write 0x85 then 0xA5
        start_cond();
        addr_phase(8'h85);
        write_phase(8'hA5);
        stop_cond();
        end_checks();
        check_output("rx_byte_hold", rx_byte, 8'hA5);

        // Address mismatch: nothing driven, WAIT_STOP until STOP
        start_cond();
        addr_phase(8'h27);
        check_output("mismatch_state", state, 4'd7);
        write_phase(8'hFF);
        check_output("mismatch_state2", state, 4'd7);
        stop_cond();
        end_checks();

        // Single-byte read, controller NACK
        tx_byte = 8'h3C;
        start_cond();
        addr_phase(8'h84);
        read_phase(1'b1, 8'h3C);
        check_output("nack_state", state, 4'd7);
        stop_cond();
        end_checks();

        // Two-byte read: ACK then NACK, tx_byte changes after the first latch
        tx_byte = 8'h11;
        start_cond();
        addr_phase(8'h84);
        wait_clks(4);
        tx_byte = 8'h22;
        read_phase(1'b0, 8'h11);
        read_phase(1'b1, 8'h22);
        stop_cond();
        end_checks();

        // Repeated START four bits into a write byte, then a read
        tx_byte = 8'hC3;
        start_cond();
        addr_phase(8'h85);
        partial = 8'hA0;
        for (int i = 7; i >= 4; i--) send_bit(partial[i], s);
        start_cond();
        check_output("rep_start_state", state, 4'd1);
        addr_phase(8'h84);
        wait_clks(2);
        check_output("rep_tx_state", state, 4'd5);
        read_phase(1'b1, 8'hC3);
        stop_cond();
        end_checks();

        // Reset while the target drives the address ACK
        start_cond();
        partial = 8'h85;
        for (int i = 7; i >= 0; i--) send_bit(partial[i], s);
        wait_clks(4);
        check_output("ack_before_reset", sda_bus, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("reset_sda_release", sda_bus, 1'b1);
        check_output("reset_state", state, 4'd0);
        check_output("reset_busy", busy, 1'b0);
        sel_model = 1'b0;
        wait_clks(2);
        reset = 1'b0;
        send_bit(1'b1, s);
        check_output("post_reset_ack", s, 1'b1);
        write_phase(8'hA5);
        check_output("post_reset_state", state, 4'd0);
        stop_cond();
        end_checks();

        // Next START works normally again
        start_cond();
        addr_phase(8'h85);
        write_phase(8'h5A);
        stop_cond();
        end_checks();
        check_output("final_rx_byte", rx_byte, 8'h5A);
    endtask

    initial begin
        reset   = 1'b1;
        scl_drv = 1'b1;
        sda_low = 1'b0;
        tx_byte = 8'h00;
        sel_model = 1'b0;
        wr_model  = 1'b0;
        wait_clks(3);
        check_output("rst_state", state, 4'd0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_rx_byte", rx_byte, 8'h00);
        check_output("rst_rx_valid", rx_valid, 1'b0);
        check_output("rst_tx_req", tx_req, 1'b0);
        check_output("rst_sda", sda_bus, 1'b1);
        reset = 1'b0;
        wait_clks(4);
        $display("[TB] starting directed transactions");
        apply_stimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42, the 7-bit target address this block responds to.
REQ-002 SHALL have port clk  input  1  system clock, at least 8x the SCL bit rate.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port scl  input  1  I2C clock from the controller, asynchronous to clk.
REQ-005 SHALL have port sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-006 SHALL have port tx_byte  input  8  read-data byte, sampled at tx_req.
REQ-007 SHALL have port tx_req  output  1  one-clk pulse when tx_byte is latched.
REQ-008 SHALL have port rx_byte  output  8  last byte written by the controller.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse when rx_byte updates.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port state  output  4  current FSM state, for debug.

Function
REQ-012 SHALL pass scl and sda-in through 2-flop synchronizers; edges detected on synchronized values; total latency pin-to-action 3 clk.
REQ-013 SHALL detect START as synced sda falling while synced scl high; STOP as sda rising while scl high.
REQ-014 SHALL sample data bits on scl rising edge and change driven sda only on scl falling edge; bit order MSB first; 3-bit counter 0..7.
REQ-015 SHALL use states IDLE=0, ADDR=1, ACK_ADDR=2, RX_BYTE=3, ACK_RX=4, TX_BYTE=5, ACK_TX=6, WAIT_STOP=7.
REQ-016 SHALL go IDLE->ADDR on START; other bus activity in IDLE ignored.
REQ-017 SHALL in ADDR shift 7 address bits then R/W bit; R/W=1 means write, R/W=0 means read.
REQ-018 SHALL on address mismatch go to WAIT_STOP without driving sda; on match go to ACK_ADDR.
REQ-019 SHALL in ACK_ADDR/ACK_RX drive sda low from the scl falling edge after bit 8 until the next scl falling edge, then release.
REQ-020 SHALL after ACK_ADDR go to RX_BYTE if write, TX_BYTE if read.
REQ-021 SHALL in RX_BYTE, on the 8th rising edge, load rx_byte, pulse rx_valid for 1 clk, go to ACK_RX; ACK_RX returns to RX_BYTE.
REQ-022 SHALL on entry to TX_BYTE latch tx_byte and pulse tx_req for 1 clk, then drive sda low for 0 bits and z for 1 bits.
REQ-023 SHALL after 8 TX bits release sda in ACK_TX and sample the controller's bit on the 9th rising edge: 0 -> TX_BYTE (new byte); 1 -> WAIT_STOP.
REQ-024 SHALL treat START in any non-IDLE state as repeated start: release sda, clear counter, go to ADDR, no rx_valid for partial byte.
REQ-025 SHALL treat STOP in any state as abort: release sda, go to IDLE; partial bytes discarded.
REQ-026 SHALL give START/STOP priority over data-bit sampling in the same clk.
REQ-027 SHALL never stretch scl.

Reset
REQ-028 SHALL on reset assertion immediately release sda (z), set state=IDLE, busy=0, rx_byte=8'h00, rx_valid=0, tx_req=0, counter=0, synchronizers to 1.
REQ-029 SHALL on reset mid-transfer ignore remaining bus activity until the next START.

Verification
REQ-030 Write: START, byte 8'h85 (0x42,W), byte 8'hA5, STOP -> sda low in both ACK slots, rx_byte=8'hA5, one rx_valid pulse, busy 0 after STOP.
REQ-031 Mismatch: START, byte 8'h27 (0x13,W), 8'hFF, STOP -> sda z throughout, no rx_valid, state WAIT_STOP then IDLE.
REQ-032 Read: START, 8'h84, tx_byte=8'h3C, controller NACK -> one tx_req, sda bits 0,0,1,1,1,1,0,0, then WAIT_STOP with sda z.
REQ-033 Read two bytes, controller ACKs first, NACKs second, tx_byte 8'h11 then 8'h22 -> two tx_req pulses, both bytes seen on sda.
REQ-034 Repeated START after 4 bits of RX_BYTE, then 8'h84 -> state ADDR then TX_BYTE, no rx_valid, address ACK driven.
REQ-035 reset asserted while driving address ACK -> sda z same cycle, state=0; following data ignored until next START.
